// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and fetch state type
package cpu_pkg;
    localparam int XLEN = 32;
    localparam int ADDR_BITS = 11;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] HALT_INSTR = 32'hFFFF_FFFF;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit ROM and IF/ID bundle
interface fetch_unit_if;
    import cpu_pkg::*;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            if_id_valid;
    logic [XLEN-1:0] if_id_instr;
    logic [XLEN-1:0] if_id_pc;
    logic            halted;

    modport master (
        output pc, if_id_valid, if_id_instr, if_id_pc, halted,
        input  instruction, stall, redirect, redirect_pc
    );

    modport slave (
        input  pc, if_id_valid, if_id_instr, if_id_pc, halted,
        output instruction, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load/hold/flush
module if_id_reg
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc
);
    // Flush only drops valid; the stale payload is kept so it never toggles needlessly.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_in;
            pc    <= pc_in;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register, next-PC mux and halt FSM (optional: FETCH_HALT_EN)
module fetch_unit
    import cpu_pkg::*;
#(
`ifdef FETCH_HALT_EN
    parameter logic [XLEN-1:0] HALT_INSTR_P = HALT_INSTR,
`endif
    parameter logic [XLEN-1:0] RESET_PC_P = RESET_PC
) (
    input logic         clk,
    input logic         rst,
    fetch_unit_if.master bus
);
    logic [XLEN-1:0] pc_q;
    logic            in_halt;
    logic            halt_hit;
    logic            load;
    logic            flush;

`ifdef FETCH_HALT_EN
    fetch_state_t state;
    assign in_halt  = (state == HALT);
    assign halt_hit = (bus.instruction == HALT_INSTR_P);
`else
    assign in_halt  = 1'b0;
    assign halt_hit = 1'b0;
`endif

    // Redirect outranks halt and stall: a halt word may itself be wrong-path.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC_P;
`ifdef FETCH_HALT_EN
            state <= FETCH;
`endif
        end else if (bus.redirect) begin
            pc_q  <= bus.redirect_pc;
`ifdef FETCH_HALT_EN
            state <= FETCH;
`endif
        end else if (!in_halt && !bus.stall) begin
            if (halt_hit) begin
`ifdef FETCH_HALT_EN
                state <= HALT;
`endif
            end else begin
                pc_q <= pc_q + 1'b1;
            end
        end
    end

    assign load  = !bus.stall && !in_halt;
    assign flush = bus.redirect || in_halt;

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .flush    (flush),
        .instr_in (bus.instruction),
        .pc_in    (pc_q),
        .valid    (bus.if_id_valid),
        .instr    (bus.if_id_instr),
        .pc       (bus.if_id_pc)
    );

    assign bus.pc     = pc_q;
    assign bus.halted = in_halt;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;
    import cpu_pkg::*;

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [XLEN-1:0] rom [0:(1<<ADDR_BITS)-1];
    always_comb bus.instruction = rom[bus.pc[ADDR_BITS-1:0]];

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] sb [$];
    logic [XLEN-1:0] exp_pc = RESET_PC;
    logic exp_valid = 1'b0;
    logic exp_halted = 1'b0;
    logic [XLEN-1:0] last_instr = '0;
    logic [XLEN-1:0] last_pc = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset(input bit st);
        @(negedge clk);
        rst = 1'b1;
        bus.stall = st;
        bus.redirect = 1'b0;
        @(posedge clk);
        #1;
        check("rst_pc", bus.pc, RESET_PC);
        check("rst_valid", {31'b0, bus.if_id_valid}, 32'd0);
        check("rst_instr", bus.if_id_instr, 32'd0);
        check("rst_if_id_pc", bus.if_id_pc, 32'd0);
        check("rst_halted", {31'b0, bus.halted}, 32'd0);
        exp_pc = RESET_PC;
        exp_valid = 1'b0;
        exp_halted = 1'b0;
        last_instr = '0;
        last_pc = '0;
        sb.delete();
    endtask

    // One clock of stimulus; expected IF/ID contents are queued when a fetch is requested.
    task automatic step(input bit st, input bit rd, input logic [XLEN-1:0] rpc);
        bit pushed = 1'b0;
        logic [XLEN-1:0] word;
        logic [63:0] e;
        @(negedge clk);
        rst = 1'b0;
        bus.stall = st;
        bus.redirect = rd;
        bus.redirect_pc = rpc;
        check("pc", bus.pc, exp_pc);
        check("halted_pre", {31'b0, bus.halted}, {31'b0, exp_halted});
        if (rd) begin
            exp_pc = rpc;
            exp_halted = 1'b0;
            exp_valid = 1'b0;
        end else if (exp_halted) begin
            exp_valid = 1'b0;
        end else if (!st) begin
            word = rom[exp_pc[ADDR_BITS-1:0]];
            sb.push_back({exp_pc, word});
            pushed = 1'b1;
            exp_valid = 1'b1;
            if (HALT_EN && word == HALT_INSTR) exp_halted = 1'b1;
            else exp_pc = exp_pc + 32'd1;
        end
        @(posedge clk);
        #1;
        check("if_id_valid", {31'b0, bus.if_id_valid}, {31'b0, exp_valid});
        check("halted_post", {31'b0, bus.halted}, {31'b0, exp_halted});
        if (pushed) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check("if_id_pc", bus.if_id_pc, e[63:32]);
                check("if_id_instr", bus.if_id_instr, e[31:0]);
                last_pc = e[63:32];
                last_instr = e[31:0];
            end
        end else begin
            check("hold_pc", bus.if_id_pc, last_pc);
            check("hold_instr", bus.if_id_instr, last_instr);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_BITS); i++) rom[i] = 32'hA500_0000 + i;
        rom[9] = HALT_INSTR;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;

        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 32'h40);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);

        step(1'b0, 1'b1, 32'd8);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) step(i % 3 == 0, 1'b0, '0);
        step(1'b0, 1'b1, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);

        step(1'b0, 1'b1, 32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);

        step(1'b0, 1'b1, 32'd9);
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);

        check("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 554 CPU, directly upstream of the instruction ROM. It owns the program counter, drives the ROM's word-addressed `pc` input, and captures the returned instruction into the IF/ID pipeline register consumed by decode. It handles pipeline stalls, branch/jump redirects with wrong-path flush, and optional halt detection.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `ADDR_BITS`, 11, ROM index width; low `ADDR_BITS` of `pc` select the ROM word.
- `HALT_INSTR`, 32'hFFFF_FFFF, encoding that stops fetch (used only with `FETCH_HALT_EN`).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `pc`  out  32  word address to the instruction ROM; registered.
- `instruction`  in  32  ROM read data for current `pc`; combinational, same cycle.
- `stall`  in  1  decode hazard; hold `pc` and the IF/ID register.
- `redirect`  in  1  taken branch/jump from a later stage.
- `redirect_pc`  in  32  target word address, valid when `redirect`=1.
- `if_id_valid`  out  1  IF/ID register holds a real instruction.
- `if_id_instr`  out  32  captured instruction.
- `if_id_pc`  out  32  address the captured instruction was fetched from.
- `halted`  out  1  fetch stopped on `HALT_INSTR`.

## Operation
- PC is word-addressed: sequential increment is +1, not +4.
- Per-edge priority: `rst` > `redirect` > halt state > `stall` > normal fetch.
- `rst`: `pc`=`RESET_PC`, `if_id_valid`=0, `if_id_instr`=0, `if_id_pc`=0, `halted`=0, state=FETCH.
- Normal fetch: `if_id_instr`<=`instruction`, `if_id_pc`<=`pc`, `if_id_valid`<=1, `pc`<=`pc`+1.
- `stall`: `pc`, `if_id_*` all hold; `if_id_valid` holds its value.
- `redirect`: `pc`<=`redirect_pc`; `if_id_valid`<=0 (flushes the wrong-path instruction); `if_id_instr`/`if_id_pc` hold their values. This applies even when `stall`=1 or in HALT.
- States: FETCH and HALT.
  - FETCH to HALT: not stalled, no redirect, `instruction`==`HALT_INSTR`. The halt word is captured valid; `pc` does not increment.
  - In HALT: `pc` frozen; `if_id_valid`<=0 every cycle; `halted`=1; `stall` ignored.
  - HALT to FETCH: `redirect` (the halt was wrong-path), or `rst`.
- Arithmetic: `pc`+1 is 32-bit modulo. 32'hFFFF_FFFF wraps to 0. The ROM aliases every 2^`ADDR_BITS` words; no fault is raised.

## Timing
- Fetch latency: 1 cycle. The instruction at `pc` appears on `if_id_*` after the next rising edge.
- First valid IF/ID: the first edge after `rst` falls, carrying `if_id_pc`=`RESET_PC`.
- Redirect penalty: 1 bubble. At edge N with `redirect`=1, `if_id_valid`=0 after N; the target instruction is valid after N+1.
- Reset mid-operation: takes effect at the next edge regardless of state, stall or redirect.
- Throughput: 1 instruction/cycle when not stalled or redirected.

## Configuration
- `FETCH_HALT_EN` defined: HALT state and `HALT_INSTR` compare are present, as described above.
- Undefined: no HALT state, `halted` is tied 0, and `HALT_INSTR` is fetched as an ordinary instruction with `pc` incrementing.

## Structure
- Shared package `cpu_pkg`:
  - `fetch_state_t` enum (FETCH, HALT).
  - `XLEN`=32 and default `RESET_PC`, `HALT_INSTR`, `ADDR_BITS` constants, shared with the instruction ROM and decode.
- Sub-module `if_id_reg`: the pipeline register, with load/hold/flush controls. `fetch_unit` holds the PC register, next-PC mux and state machine.

## Test plan
- Reset release, ROM words 0..3 = A,B,C,D:
  - `pc` reads 0,1,2,3 on successive cycles.
  - `if_id_instr` = A,B,C with `if_id_pc` = 0,1,2; `if_id_valid` rises one edge after `rst` falls.
- `stall` high for 3 cycles at `pc`=5: `pc` stays 5 and `if_id_*` stay constant; fetch resumes at 5, with no instruction skipped or duplicated.
- `redirect` to 0x40 at `pc`=7, with `stall`=1 on the same cycle:
  - Next cycle: `pc`=0x40, `if_id_valid`=0.
  - Following cycle: `if_id_pc`=0x40, `if_id_valid`=1.
- `FETCH_HALT_EN` defined, ROM word 9 = 32'hFFFF_FFFF:
  - `if_id_instr`=FFFF_FFFF valid once; then `halted`=1, `pc` stuck at 9, `if_id_valid`=0 for 10 cycles.
  - A later `redirect` to 0 clears `halted` and resumes fetch at 0.
- `redirect_pc`=32'hFFFF_FFFE with no stalls: `pc` sequence FFFF_FFFE, FFFF_FFFF, 0, 1; ROM reads wrap onto index 2046, 2047, 0, 1.
- Assert `rst` while in HALT with `stall`=1: after the edge all outputs are at reset values and `pc`=`RESET_PC`.
